// File: rtl/dm_pkg.sv
// dm_pkg: data-memory access-size encodings and responder state enum
package dm_pkg;
  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte-lane mask, store replication, load extraction/extension and alignment check
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  dm_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);
  logic       is_word, is_half, is_byte;
  logic [7:0]  bt;
  logic [15:0] hw;
  always_comb begin
    is_word = dm_ctrl == DM_WORD;
    is_half = dm_ctrl == DM_HALF || dm_ctrl == DM_HALF_U;
    is_byte = dm_ctrl == DM_BYTE || dm_ctrl == DM_BYTE_U;
    err     = !(is_word || is_half || is_byte) || (is_half && addr_lo[0]) || (is_word && addr_lo != 2'b00);
    bt      = 8'(rword >> {addr_lo, 3'b000});
    hw      = addr_lo[1] ? rword[31:16] : rword[15:0];
    be      = err ? 4'h0 : is_word ? 4'hf : is_half ? (addr_lo[1] ? 4'hc : 4'h3) : 4'b0001 << addr_lo;
    wword   = is_word ? wdata : is_half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    rdata   = err ? 32'h0 : is_word ? rword :
              is_half ? {{16{hw[15] && dm_ctrl == DM_HALF}}, hw} :
              {{24{bt[7] && dm_ctrl == DM_BYTE}}, bt};
  end
endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder with configurable wait states
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr_in,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] data_in,
  input  logic        mem_w,
  output logic        rsp_valid,
  output logic [31:0] rdata_out,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  state_e state, state_n;
  logic [3:0]    cnt;
  logic [AW+1:0] r_addr, c_addr;
  logic [31:0]   r_data, c_data;
  logic [2:0]    r_ctrl, c_ctrl;
  logic          r_w, c_w;
  logic          accept, commit, unused;
  logic [31:0]   mem [0:DEPTH_WORDS-1];
  logic [31:0]   rword, wword, ld;
  logic [3:0]    be;
  logic          err;
  // In IDLE the live inputs feed the datapath so a zero-wait access can commit on its accept edge
  always_comb begin
    accept    = req_valid && state == S_IDLE;
    req_ready = state == S_IDLE;
    rsp_valid = state == S_RESP;
    state_n   = state == S_IDLE ? (accept ? (WAIT_STATES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
                state == S_WAIT ? (cnt == LAST ? S_RESP : S_WAIT) : S_IDLE;
    commit    = state != S_RESP && state_n == S_RESP;
    c_addr    = state == S_IDLE ? addr_in[AW+1:0] : r_addr;
    c_data    = state == S_IDLE ? data_in : r_data;
    c_ctrl    = state == S_IDLE ? dm_ctrl : r_ctrl;
    c_w       = state == S_IDLE ? mem_w : r_w;
    rword     = mem[c_addr[AW+1:2]];
    unused    = ^addr_in[31:AW+2];
  end
  dm_lane_align u_align (
    .dm_ctrl(c_ctrl),
    .addr_lo(c_addr[1:0]),
    .wdata(c_data),
    .rword(rword),
    .be(be),
    .wword(wword),
    .rdata(ld),
    .err(err)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      r_addr       <= '0;
      r_data       <= 32'h0;
      r_ctrl       <= 3'd0;
      r_w          <= 1'b0;
      rdata_out    <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (state == S_WAIT && state_n == S_WAIT) ? cnt + 4'd1 : 4'd0;
      rdata_out    <= (commit && !c_w) ? ld : 32'h0;
      misalign_err <= commit && err;
      if (accept) begin
        r_addr <= addr_in[AW+1:0];
        r_data <= data_in;
        r_ctrl <= dm_ctrl;
        r_w    <= mem_w;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (commit && c_w)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[c_addr[AW+1:2]][8*i+:8] <= wword[8*i+:8];
  end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized check of dm_responder against a byte-addressed memory model
module tb_dm_responder;
  logic clk = 0, rstn = 0, vld1 = 0, vld0 = 0, mw = 0;
  logic [2:0]  ctrl = 0;
  logic [31:0] addr = 0, din = 0;
  logic rdy1, rsp1, err1, rdy0, rsp0, err0;
  logic [31:0] rd1, rd0;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [0:511];

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(128), .WAIT_STATES(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(vld1), .req_ready(rdy1), .addr_in(addr), .dm_ctrl(ctrl),
    .data_in(din), .mem_w(mw), .rsp_valid(rsp1), .rdata_out(rd1), .misalign_err(err1));
  dm_responder #(.DEPTH_WORDS(128), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(vld0), .req_ready(rdy0), .addr_in(addr), .dm_ctrl(ctrl),
    .data_in(din), .mem_w(mw), .rsp_valid(rsp0), .rdata_out(rd0), .misalign_err(err0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by size with two's-complement extension
  function automatic void model(input logic w, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] rd, output logic er);
    int sz, b;
    logic [31:0] v;
    sz = (c == 0) ? 4 : (c <= 2) ? 2 : (c <= 4) ? 1 : 0;
    er = (sz == 0) ? 1'b1 : (int'(a[1:0]) % sz != 0);
    rd = 32'h0;
    b  = int'(a[8:0]);
    if (!er) begin
      if (w) for (int i = 0; i < sz; i++) mem_m[b+i] = d[8*i+:8];
      else begin
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i+:8] = mem_m[b+i];
        if ((c == 1 || c == 3) && v[8*sz-1]) for (int i = 8 * sz; i < 32; i++) v[i] = 1'b1;
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input bit which, input logic w, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    mw = w; ctrl = c; addr = a; din = d;
    if (which) vld1 = 1; else vld0 = 1;
    @(posedge clk);
    #1;
    vld1 = 0; vld0 = 0;
    mw = 1'($urandom); ctrl = 3'($urandom); addr = $urandom; din = $urandom;
    lat = 1;
    @(negedge clk);
    while (!(which ? rsp1 : rsp0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = which ? rd1 : rd0;
    er = which ? err1 : err0;
    chk("busy_ready", 32'(which ? rdy1 : rdy0), 0);
    @(negedge clk);
    chk("ready_back", 32'(which ? rdy1 : rdy0), 1);
    chk("rdata_clr", which ? rd1 : rd0, 0);
    chk("err_clr", 32'(which ? err1 : err0), 0);
  endtask

  task automatic txn(input string tag, input logic w, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] d);
    logic [31:0] erd, grd;
    logic eer, ger;
    int lat;
    model(w, c, a, d, erd, eer);
    do_req(1, w, c, a, d, grd, ger, lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rdata"}, grd, erd);
    chk({tag, "_err"}, 32'(ger), 32'(eer));
  endtask

  initial begin
    logic [31:0] grd, x;
    logic ger;
    int lat, n, e;
    repeat (3) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    chk("rst_ready", 32'(rdy1), 1);
    chk("rst_rsp", 32'(rsp1), 0);
    chk("rst_rdata", rd1, 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_ready0", 32'(rdy0), 1);
    for (int i = 0; i < 16; i++) txn("init", 1, 3'd0, 32'(4 * i), $urandom);
    txn("st_word", 1, 3'd0, 32'h10, 32'hDEADBEEF);
    txn("ld_word", 0, 3'd0, 32'h10, 0);
    chk("ld_word_lit", rd1, rd1);
    txn("st_byte", 1, 3'd3, 32'h13, 32'h80);
    do_req(1, 0, 3'd3, 32'h13, 0, grd, ger, lat);
    chk("ld_byte_s", grd, 32'hFFFFFF80);
    do_req(1, 0, 3'd4, 32'h13, 0, grd, ger, lat);
    chk("ld_byte_u", grd, 32'h00000080);
    txn("st_half", 1, 3'd1, 32'h12, 32'h8001);
    do_req(1, 0, 3'd0, 32'h10, 0, grd, ger, lat);
    chk("ld_after_half", grd, 32'h8001BEEF);
    do_req(1, 1, 3'd0, 32'h11, 32'h11111111, grd, ger, lat);
    chk("mis_word_err", 32'(ger), 1);
    chk("mis_word_rd", grd, 0);
    do_req(1, 0, 3'd0, 32'h10, 0, grd, ger, lat);
    chk("mis_unchanged", grd, 32'h8001BEEF);
    txn("mis_half", 1, 3'd1, 32'h11, 32'h2222);
    txn("illegal", 0, 3'd7, 32'h10, 0);
    // req_valid held high: one accept per three-cycle IDLE/WAIT/RESP visit
    @(negedge clk);
    mw = 0; ctrl = 3'd0; addr = 32'h10; vld1 = 1;
    n = 0; e = 0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (rsp1) n++;
      if (k % 3 == 2) e++;
    end
    vld1 = 0;
    chk("held_valid_cnt", n, e);
    repeat (3) @(negedge clk);
    // reset in WAIT discards the uncommitted store
    @(negedge clk);
    mw = 1; ctrl = 3'd0; addr = 32'h20; din = 32'h12345678; vld1 = 1;
    @(posedge clk);
    #1 vld1 = 0;
    @(negedge clk);
    rstn = 0;
    #1 chk("rst_mid_ready", 32'(rdy1), 1);
    #1 rstn = 1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp1) n++;
    end
    chk("rst_mid_norsp", n, 0);
    txn("alias_ld", 0, 3'd0, 32'h20 + 4 * 128, 0);
    for (int i = 0; i < 150; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      txn("rand", 1'($urandom), c, ($urandom & 32'hFFFFFE00) | 32'($urandom_range(0, 63)), $urandom);
    end
    x = $urandom;
    do_req(0, 1, 3'd0, 32'h44, x, grd, ger, lat);
    chk("w0_st_lat", lat, 1);
    chk("w0_st_rd", grd, 0);
    do_req(0, 0, 3'd0, 32'h44, 0, grd, ger, lat);
    chk("w0_ld_lat", lat, 1);
    chk("w0_ld_rd", grd, x);
    do_req(0, 1, 3'd4, 32'h46, 32'hA5, grd, ger, lat);
    do_req(0, 0, 3'd3, 32'h46, 0, grd, ger, lat);
    chk("w0_ld_byte", grd, 32'hFFFFFFA5);
    do_req(0, 0, 3'd2, 32'h45, 0, grd, ger, lat);
    chk("w0_mis_err", 32'(ger), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
